bw_meas_ctrl: RTL and testbench

Sequences one left-edge finder and one right-edge finder per accumulated spectrum frame. It accepts a frame from the accumulator stage and freezes it. It then starts both finders in the same cycle, collects their edge pairs, checks the results, and computes occupied bandwidth in bins. The result is presented on a valid/ready interface to the downstream reporting logic.

---
 rtl/bw_meas_pkg.sv | 23 ++
 rtl/bw_edge_latch.sv | 41 ++++
 rtl/bw_meas_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_bw_meas_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bw_meas_pkg.sv
// Shared types for the bandwidth measurement controller: FSM states, result
// status codes and the width of the optional statistics counters.
package bw_meas_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      CALC,
      OUT
   } ctrl_state_e;

   typedef enum logic [2:0] {
      OK        = 3'd0,
      NO_LEFT   = 3'd1,
      NO_RIGHT  = 3'd2,
      NO_EDGES  = 3'd3,
      BAD_ORDER = 3'd4,
      TIMEOUT   = 3'd5
   } bw_status_e;

   localparam int STATS_W = 16;

endpackage

// File: rtl/bw_edge_latch.sv
// Holds one edge finder's result: the first done pulse of a frame captures
// both bins and sets the done flag until clear_i.
module bw_edge_latch #(
   parameter int FREQ_BIN_WIDTH = 9
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clear_i,
   input  logic                      capture_en_i,
   input  logic                      valid_i,
   input  logic [FREQ_BIN_WIDTH-1:0] f1_i,
   input  logic [FREQ_BIN_WIDTH-1:0] f2_i,
   output logic                      done_next_o,
   output logic [FREQ_BIN_WIDTH-1:0] f1_o,
   output logic [FREQ_BIN_WIDTH-1:0] f2_o
);

   logic done_q;
   logic capture;

   assign capture     = capture_en_i && valid_i && !done_q;
   // Lookahead lets the controller leave RUN in the same cycle the last pulse lands.
   assign done_next_o = done_q || capture;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         done_q <= 1'b0;
         f1_o   <= '0;
         f2_o   <= '0;
      end else if (clear_i) begin
         done_q <= 1'b0;
         f1_o   <= '0;
         f2_o   <= '0;
      end else if (capture) begin
         done_q <= 1'b1;
         f1_o   <= f1_i;
         f2_o   <= f2_i;
      end
   end

endmodule

// File: rtl/bw_meas_ctrl.sv
// Frame sequencer for the left/right edge finders; produces occupied bandwidth.
// Optional BW_MEAS_STATS_EN adds saturating handshake/error counters.
module bw_meas_ctrl
   import bw_meas_pkg::*;
#(
   parameter int FREQ_BIN_WIDTH = 9,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int NUM_ACCUMS     = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      frame_valid_i,
   output logic                      frame_ready_o,
   output logic                      frame_lock_o,
   input  logic                      abort_i,
   output logic                      left_start_o,
   input  logic                      left_valid_i,
   input  logic [FREQ_BIN_WIDTH-1:0] left_f1_i,
   input  logic [FREQ_BIN_WIDTH-1:0] left_f2_i,
   output logic                      right_start_o,
   input  logic                      right_valid_i,
   input  logic [FREQ_BIN_WIDTH-1:0] right_f1_i,
   input  logic [FREQ_BIN_WIDTH-1:0] right_f2_i,
   output logic                      result_valid_o,
   input  logic                      result_ready_i,
   output logic [FREQ_BIN_WIDTH-1:0] f_left_o,
   output logic [FREQ_BIN_WIDTH-1:0] f_right_o,
   output logic [FREQ_BIN_WIDTH:0]   bw_bins_o,
   output logic [2:0]                status_o
`ifdef BW_MEAS_STATS_EN
   ,
   output logic [STATS_W-1:0]        frames_done_o,
   output logic [STATS_W-1:0]        errors_o
`endif
);

   localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   generate
      if (TIMEOUT_CYCLES < NUM_ACCUMS + 4) begin : g_cfg_check
         $error("bw_meas_ctrl: TIMEOUT_CYCLES must be at least NUM_ACCUMS+4");
      end
   endgenerate

   ctrl_state_e               state_q;
   bw_status_e                status_q;
   logic [TMR_W-1:0]          timer_q;
   logic                      l_done_nxt, r_done_nxt;
   logic [FREQ_BIN_WIDTH-1:0] l_f1, l_f2, r_f1, r_f2;
   logic                      accept, abort_act, handshake;

   assign accept    = (state_q == IDLE) && frame_valid_i;
   assign abort_act = abort_i && (state_q != IDLE);
   assign handshake = (state_q == OUT) && result_ready_i && !abort_act;
   assign status_o  = status_q;

   function automatic bw_status_e calc_status(
      input logic [FREQ_BIN_WIDTH-1:0] lf1, lf2, rf1, rf2);
      logic l_none, r_none;
      l_none = (lf1 == '0) && (lf2 == '0);
      r_none = (rf1 == '0) && (rf2 == '0);
      if (l_none && r_none)  return NO_EDGES;
      else if (l_none)       return NO_LEFT;
      else if (r_none)       return NO_RIGHT;
      else if (rf1 < lf2)    return BAD_ORDER;
      else                   return OK;
   endfunction

   // One extra bit so a full-span measurement (0..max) cannot wrap.
   function automatic logic [FREQ_BIN_WIDTH:0] calc_bw(
      input logic [FREQ_BIN_WIDTH-1:0] f_lo, f_hi);
      return {1'b0, f_hi} - {1'b0, f_lo} + (FREQ_BIN_WIDTH+1)'(1);
   endfunction

   bw_edge_latch #(.FREQ_BIN_WIDTH(FREQ_BIN_WIDTH)) u_left (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (accept || abort_act),
      .capture_en_i (state_q == RUN),
      .valid_i      (left_valid_i),
      .f1_i         (left_f1_i),
      .f2_i         (left_f2_i),
      .done_next_o  (l_done_nxt),
      .f1_o         (l_f1),
      .f2_o         (l_f2)
   );

   bw_edge_latch #(.FREQ_BIN_WIDTH(FREQ_BIN_WIDTH)) u_right (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (accept || abort_act),
      .capture_en_i (state_q == RUN),
      .valid_i      (right_valid_i),
      .f1_i         (right_f1_i),
      .f2_i         (right_f2_i),
      .done_next_o  (r_done_nxt),
      .f1_o         (r_f1),
      .f2_o         (r_f2)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= IDLE;
         status_q       <= OK;
         timer_q        <= '0;
         frame_ready_o  <= 1'b1;
         frame_lock_o   <= 1'b0;
         left_start_o   <= 1'b0;
         right_start_o  <= 1'b0;
         result_valid_o <= 1'b0;
         f_left_o       <= '0;
         f_right_o      <= '0;
         bw_bins_o      <= '0;
      end else begin
         left_start_o  <= 1'b0;
         right_start_o <= 1'b0;
         if (abort_act) begin
            state_q        <= IDLE;
            frame_ready_o  <= 1'b1;
            frame_lock_o   <= 1'b0;
            result_valid_o <= 1'b0;
            timer_q        <= '0;
         end else begin
            case (state_q)
               IDLE: if (frame_valid_i) begin
                  state_q       <= RUN;
                  frame_ready_o <= 1'b0;
                  frame_lock_o  <= 1'b1;
                  left_start_o  <= 1'b1;
                  right_start_o <= 1'b1;
                  timer_q       <= '0;
               end
               RUN: begin
                  if (l_done_nxt && r_done_nxt) begin
                     state_q <= CALC;
                  end else if (timer_q == TMR_LAST) begin
                     state_q        <= OUT;
                     status_q       <= TIMEOUT;
                     bw_bins_o      <= '0;
                     f_left_o       <= l_f2;
                     f_right_o      <= r_f1;
                     result_valid_o <= 1'b1;
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
               CALC: begin
                  state_q        <= OUT;
                  status_q       <= calc_status(l_f1, l_f2, r_f1, r_f2);
                  bw_bins_o      <= (calc_status(l_f1, l_f2, r_f1, r_f2) == OK) ?
                                    calc_bw(l_f2, r_f1) : '0;
                  f_left_o       <= l_f2;
                  f_right_o      <= r_f1;
                  result_valid_o <= 1'b1;
               end
               OUT: if (result_ready_i) begin
                  state_q        <= IDLE;
                  frame_ready_o  <= 1'b1;
                  frame_lock_o   <= 1'b0;
                  result_valid_o <= 1'b0;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

`ifdef BW_MEAS_STATS_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frames_done_o <= '0;
         errors_o      <= '0;
      end else if (handshake) begin
         if (frames_done_o != '1)                  frames_done_o <= frames_done_o + 1'b1;
         if ((status_q != OK) && (errors_o != '1)) errors_o      <= errors_o + 1'b1;
      end
   end
`else
   logic unused_handshake;
   assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_bw_meas_ctrl.sv
// Directed bench for bw_meas_ctrl; honours BW_MEAS_STATS_EN when defined.
module tb_bw_meas_ctrl;
   import bw_meas_pkg::*;

   localparam int W = 9;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         frame_valid = 1'b0, abort = 1'b0, result_ready = 1'b0;
   logic         left_valid = 1'b0, right_valid = 1'b0;
   logic [W-1:0] left_f1 = '0, left_f2 = '0, right_f1 = '0, right_f2 = '0;
   logic         frame_ready, frame_lock, left_start, right_start, result_valid;
   logic [W-1:0] f_left, f_right;
   logic [W:0]   bw_bins;
   logic [2:0]   status;
`ifdef BW_MEAS_STATS_EN
   logic [STATS_W-1:0] frames_done, err_cnt;
   int exp_frames = 0, exp_errs = 0;
`endif

   int errors = 0;
   int checks = 0;
   int extra_starts;

   always #5 clk = ~clk;

   bw_meas_ctrl dut (
      .clk_i(clk), .rst_ni(rst_n),
      .frame_valid_i(frame_valid), .frame_ready_o(frame_ready), .frame_lock_o(frame_lock),
      .abort_i(abort),
      .left_start_o(left_start), .left_valid_i(left_valid), .left_f1_i(left_f1), .left_f2_i(left_f2),
      .right_start_o(right_start), .right_valid_i(right_valid), .right_f1_i(right_f1), .right_f2_i(right_f2),
      .result_valid_o(result_valid), .result_ready_i(result_ready),
      .f_left_o(f_left), .f_right_o(f_right), .bw_bins_o(bw_bins), .status_o(status)
`ifdef BW_MEAS_STATS_EN
      , .frames_done_o(frames_done), .errors_o(err_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept();
      frame_valid = 1'b1;
      step();
      frame_valid = 1'b0;
   endtask

   // Cycle 0 is the first RUN cycle; lc/rc < 0 means that finder never answers.
   task automatic collect(input int lc, input int rc,
                          input logic [W-1:0] lf1, input logic [W-1:0] lf2,
                          input logic [W-1:0] rf1, input logic [W-1:0] rf2,
                          output int lat);
      lat = -1;
      extra_starts = 0;
      for (int c = 0; c < 100; c++) begin
         if (c > 0 && (left_start || right_start)) extra_starts++;
         if (result_valid) begin
            lat = c;
            break;
         end
         left_valid  = (c == lc);
         right_valid = (c == rc);
         left_f1 = lf1; left_f2 = lf2; right_f1 = rf1; right_f2 = rf2;
         step();
      end
      left_valid  = 1'b0;
      right_valid = 1'b0;
   endtask

   task automatic handshake(input bit bad);
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
`ifdef BW_MEAS_STATS_EN
      exp_frames++;
      if (bad) exp_errs++;
`else
      if (bad) begin end
`endif
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", frame_ready); end
      checks++; if ({frame_lock, left_start, right_start, result_valid} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {frame_lock, left_start, right_start, result_valid}); end
      checks++; if ({f_left, f_right, bw_bins, status} !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", {f_left, f_right, bw_bins, status}); end
      rst_n = 1'b1;
      step();
      checks++; if (frame_ready !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL post_reset: ready=%0b valid=%0b want 1/0", frame_ready, result_valid); end
`ifdef BW_MEAS_STATS_EN
      checks++; if (frames_done !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", frames_done, err_cnt); end
`endif
   endtask

   task automatic test_basic();
      int lat;
      accept();
      checks++; if ({left_start, right_start} !== 2'b11) begin errors++; $display("FAIL start_pulse: got %b want 11", {left_start, right_start}); end
      checks++; if (frame_lock !== 1'b1 || frame_ready !== 1'b0) begin errors++; $display("FAIL accept_lock: lock=%0b ready=%0b want 1/0", frame_lock, frame_ready); end
      collect(9, 11, 9'd3, 9'd200, 9'd215, 9'd230, lat);
      checks++; if (lat !== 13) begin errors++; $display("FAIL basic_latency: got %0d want 13", lat); end
      checks++; if (extra_starts !== 0) begin errors++; $display("FAIL start_repeat: got %0d want 0", extra_starts); end
      checks++; if (status !== 3'd0 || bw_bins !== 10'd16) begin errors++; $display("FAIL basic_result: status=%0d bw=%0d want 0/16", status, bw_bins); end
      checks++; if (f_left !== 9'd200 || f_right !== 9'd215) begin errors++; $display("FAIL basic_edges: got %0d/%0d want 200/215", f_left, f_right); end
      handshake(1'b0);
      checks++; if ({result_valid, frame_lock, frame_ready} !== 3'b001) begin errors++; $display("FAIL basic_release: got %b want 001", {result_valid, frame_lock, frame_ready}); end
   endtask

   task automatic test_same_cycle();
      int lat;
      accept();
      collect(3, 3, 9'd90, 9'd100, 9'd100, 9'd110, lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL same_latency: got %0d want 5", lat); end
      checks++; if (status !== 3'd0 || bw_bins !== 10'd1) begin errors++; $display("FAIL same_result: status=%0d bw=%0d want 0/1", status, bw_bins); end
      handshake(1'b0);
   endtask

   task automatic test_status_codes();
      logic [W-1:0] tl1 [5], tl2 [5], tr1 [5], tr2 [5];
      int ts [5], tbw [5];
      int lat;
      tl1 = '{9'd0, 9'd0, 9'd40, 9'd290, 9'd5};
      tl2 = '{9'd0, 9'd0, 9'd45, 9'd300, 9'd0};
      tr1 = '{9'd50, 9'd0, 9'd0, 9'd100, 9'd511};
      tr2 = '{9'd60, 9'd0, 9'd0, 9'd120, 9'd511};
      ts  = '{1, 3, 2, 4, 0};
      tbw = '{0, 0, 0, 0, 512};
      for (int i = 0; i < 5; i++) begin
         accept();
         collect(4, 6, tl1[i], tl2[i], tr1[i], tr2[i], lat);
         checks++; if (lat !== 8) begin errors++; $display("FAIL status_latency[%0d]: got %0d want 8", i, lat); end
         checks++; if (status !== 3'(ts[i]) || bw_bins !== 10'(tbw[i])) begin errors++; $display("FAIL status_case[%0d]: status=%0d bw=%0d want %0d/%0d", i, status, bw_bins, ts[i], tbw[i]); end
         checks++; if (f_left !== tl2[i] || f_right !== tr1[i]) begin errors++; $display("FAIL status_edges[%0d]: got %0d/%0d want %0d/%0d", i, f_left, f_right, tl2[i], tr1[i]); end
         handshake(ts[i] != 0);
      end
   endtask

   task automatic test_timeout();
      int lat;
      logic [W-1:0] held_right;
      accept();
      collect(5, -1, 9'd1, 9'd2, 9'd0, 9'd0, lat);
      checks++; if (lat !== 64) begin errors++; $display("FAIL timeout_latency: got %0d want 64", lat); end
      checks++; if (status !== 3'd5 || bw_bins !== 10'd0) begin errors++; $display("FAIL timeout_result: status=%0d bw=%0d want 5/0", status, bw_bins); end
      held_right = f_right;
      right_valid = 1'b1; right_f1 = 9'd7; right_f2 = 9'd9;
      step();
      right_valid = 1'b0;
      step();
      checks++; if (result_valid !== 1'b1 || status !== 3'd5 || bw_bins !== 10'd0 || f_right !== held_right) begin errors++; $display("FAIL late_pulse: valid=%0b status=%0d bw=%0d fr=%0d want 1/5/0/%0d", result_valid, status, bw_bins, f_right, held_right); end
      handshake(1'b1);
   endtask

   task automatic test_backpressure();
      int lat;
      accept();
      collect(2, 2, 9'd0, 9'd10, 9'd20, 9'd30, lat);
      checks++; if (lat !== 4 || bw_bins !== 10'd11) begin errors++; $display("FAIL bp_result: lat=%0d bw=%0d want 4/11", lat, bw_bins); end
      frame_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if ({result_valid, frame_lock, frame_ready, left_start} !== 4'b1100 || bw_bins !== 10'd11 || f_left !== 9'd10) begin errors++; $display("FAIL bp_hold[%0d]: ctrl=%b bw=%0d fl=%0d want 1100/11/10", i, {result_valid, frame_lock, frame_ready, left_start}, bw_bins, f_left); end
      end
      handshake(1'b0);
      checks++; if ({result_valid, frame_lock, frame_ready} !== 3'b001) begin errors++; $display("FAIL bp_release: got %b want 001", {result_valid, frame_lock, frame_ready}); end
      step();
      frame_valid = 1'b0;
      checks++; if ({left_start, right_start, frame_lock} !== 3'b111) begin errors++; $display("FAIL bp_reaccept: got %b want 111", {left_start, right_start, frame_lock}); end
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++; if ({result_valid, frame_lock, frame_ready} !== 3'b001) begin errors++; $display("FAIL abort_run: got %b want 001", {result_valid, frame_lock, frame_ready}); end
   endtask

   task automatic test_abort();
      int lat;
      accept();
      left_valid = 1'b1; left_f1 = 9'd0; left_f2 = 9'd50;
      step();
      left_valid = 1'b0;
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++; if ({result_valid, frame_lock, frame_ready} !== 3'b001) begin errors++; $display("FAIL abort_flag_run: got %b want 001", {result_valid, frame_lock, frame_ready}); end
      accept();
      collect(4, 2, 9'd0, 9'd60, 9'd70, 9'd80, lat);
      checks++; if (lat !== 6 || f_left !== 9'd60 || bw_bins !== 10'd11) begin errors++; $display("FAIL abort_flags_cleared: lat=%0d fl=%0d bw=%0d want 6/60/11", lat, f_left, bw_bins); end
      abort = 1'b1; result_ready = 1'b1;
      step();
      abort = 1'b0; result_ready = 1'b0;
      checks++; if ({result_valid, frame_lock, frame_ready} !== 3'b001) begin errors++; $display("FAIL abort_out: got %b want 001", {result_valid, frame_lock, frame_ready}); end
`ifdef BW_MEAS_STATS_EN
      checks++; if (frames_done !== 16'(exp_frames) || err_cnt !== 16'(exp_errs)) begin errors++; $display("FAIL abort_stats: got %0d/%0d want %0d/%0d", frames_done, err_cnt, exp_frames, exp_errs); end
`endif
      left_valid = 1'b1; left_f2 = 9'd77;
      step();
      left_valid = 1'b0;
      accept();
      collect(6, 2, 9'd0, 9'd80, 9'd90, 9'd91, lat);
      checks++; if (lat !== 8 || f_left !== 9'd80) begin errors++; $display("FAIL idle_stray: lat=%0d fl=%0d want 8/80", lat, f_left); end
      handshake(1'b0);
`ifdef BW_MEAS_STATS_EN
      checks++; if (frames_done !== 16'(exp_frames) || err_cnt !== 16'(exp_errs)) begin errors++; $display("FAIL stats_count: got %0d/%0d want %0d/%0d", frames_done, err_cnt, exp_frames, exp_errs); end
`endif
   endtask

   task automatic test_async_reset();
      accept();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({frame_ready, frame_lock, left_start, result_valid} !== 4'b1000) begin errors++; $display("FAIL async_reset: got %b want 1000", {frame_ready, frame_lock, left_start, result_valid}); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++; if (frame_ready !== 1'b1 || frame_lock !== 1'b0) begin errors++; $display("FAIL async_release: ready=%0b lock=%0b want 1/0", frame_ready, frame_lock); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_same_cycle();
      test_status_codes();
      test_timeout();
      test_backpressure();
      test_abort();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
